// File: rtl/lsu_types.sv
// Shared load/store-unit types: data-memory port FSM states, arbiter grant
// encoding and the registered cache request.
package lsu_types;

  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_TAG_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } dmem_state_t;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } grant_t;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0] addr;
    logic [3:0]            rmask;
    logic [3:0]            wmask;
    logic [31:0]           wdata;
    logic [LSU_TAG_W-1:0]  tag;
  } dmem_req_t;

  function automatic logic [LSU_ADDR_W-1:0] word_align(input logic [LSU_ADDR_W-1:0] a);
    return {a[LSU_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the load and store request channels.
// When both request, the channel that did not win last time is granted.
module rr_arb2
  import lsu_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_ld,
  input  logic req_st,
  output logic gnt_ld,
  output logic gnt_st
);

  grant_t last_grant;

  always_comb begin
    gnt_ld = 1'b0;
    gnt_st = 1'b0;
    if (en) begin
      if (req_st && req_ld) begin
        gnt_st = (last_grant == LOAD);
        gnt_ld = (last_grant == STORE);
      end else begin
        gnt_st = req_st;
        gnt_ld = req_ld;
      end
    end
  end

  // LOAD at reset so the first contended grant goes to the store queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= LOAD;
    end else if (gnt_st) begin
      last_grant <= STORE;
    end else if (gnt_ld) begin
      last_grant <= LOAD;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates store-queue and load-queue requests onto the single-ported dcache,
// one outstanding access at a time, and returns tagged load data.
module dmem_port_arbiter
  import lsu_types::*;
#(
  parameter int unsigned LDQ_TAG_W = LSU_TAG_W,
  parameter int unsigned ADDR_W    = LSU_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 backend_flush,
  input  logic                 stq_valid,
  output logic                 stq_ready,
  input  logic [ADDR_W-1:0]    stq_addr,
  input  logic [3:0]           stq_wmask,
  input  logic [31:0]          stq_wdata,
  input  logic                 ldq_valid,
  output logic                 ldq_ready,
  input  logic [ADDR_W-1:0]    ldq_addr,
  input  logic [3:0]           ldq_rmask,
  input  logic [LDQ_TAG_W-1:0] ldq_tag,
  output logic                 ldq_resp_valid,
  output logic [LDQ_TAG_W-1:0] ldq_resp_tag,
  output logic [31:0]          ldq_resp_rdata,
  output logic [ADDR_W-1:0]    dcache_addr,
  output logic [3:0]           dcache_rmask,
  output logic [3:0]           dcache_wmask,
  output logic [31:0]          dcache_wdata,
  input  logic [31:0]          dcache_rdata,
  input  logic                 dcache_resp
);

  // The request register uses the package widths; the parameters are expected
  // to keep their defaults so both views agree.
  dmem_state_t          state;
  dmem_state_t          state_nxt;
  dmem_req_t            req_q;
  logic                 drop_q;
  logic                 resp_pend_q;
  logic [LDQ_TAG_W-1:0] resp_tag_q;
  logic [31:0]          resp_rdata_q;
  logic                 accept_en;
  logic                 gnt_ld;
  logic                 gnt_st;
  logic                 ld_done;
  logic                 ld_deliver;

  // Ready is also masked by rst so every output reads 0 while reset is held.
  assign accept_en = (state == IDLE) && !backend_flush && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_en),
    .req_ld (ldq_valid),
    .req_st (stq_valid),
    .gnt_ld (gnt_ld),
    .gnt_st (gnt_st)
  );

  assign stq_ready = gnt_st;
  assign ldq_ready = gnt_ld;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_st) begin
          state_nxt = ST_WAIT;
        end else if (gnt_ld) begin
          state_nxt = LD_WAIT;
        end
      end
      LD_WAIT, ST_WAIT: begin
        if (dcache_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (gnt_st) begin
      req_q <= '{addr: word_align(stq_addr), rmask: 4'h0, wmask: stq_wmask,
                 wdata: stq_wdata, tag: '0};
    end else if (gnt_ld) begin
      req_q <= '{addr: word_align(ldq_addr), rmask: ldq_rmask, wmask: 4'h0,
                 wdata: 32'h0, tag: ldq_tag};
    end
  end

  // A flushed load cannot be cancelled at the cache, so remember to discard it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if (state == LD_WAIT) begin
      if (dcache_resp) begin
        drop_q <= 1'b0;
      end else if (backend_flush) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign ld_done    = (state == LD_WAIT) && dcache_resp;
  assign ld_deliver = ld_done && !drop_q && !backend_flush;

  // Tag/data only move on a delivered load, so they hold while valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pend_q  <= 1'b0;
      resp_tag_q   <= '0;
      resp_rdata_q <= '0;
    end else begin
      resp_pend_q <= ld_deliver;
      if (ld_deliver) begin
        resp_tag_q   <= req_q.tag;
        resp_rdata_q <= dcache_rdata;
      end
    end
  end

  assign ldq_resp_valid = resp_pend_q && !backend_flush;
  assign ldq_resp_tag   = resp_tag_q;
  assign ldq_resp_rdata = resp_rdata_q;

  assign dcache_addr  = req_q.addr;
  assign dcache_wdata = req_q.wdata;
  assign dcache_rmask = (state == LD_WAIT) ? req_q.rmask : 4'h0;
  assign dcache_wmask = (state == ST_WAIT) ? req_q.wmask : 4'h0;

  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !((state == IDLE) && dcache_resp));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table of single accesses, hand-written
// flush/reset sequences, and a queue of expected load responses.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        backend_flush = 1'b0;
  logic        stq_valid = 1'b0;
  logic        stq_ready;
  logic [31:0] stq_addr = '0;
  logic [3:0]  stq_wmask = '0;
  logic [31:0] stq_wdata = '0;
  logic        ldq_valid = 1'b0;
  logic        ldq_ready;
  logic [31:0] ldq_addr = '0;
  logic [3:0]  ldq_rmask = '0;
  logic [2:0]  ldq_tag = '0;
  logic        ldq_resp_valid;
  logic [2:0]  ldq_resp_tag;
  logic [31:0] ldq_resp_rdata;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_rmask;
  logic [3:0]  dcache_wmask;
  logic [31:0] dcache_wdata;
  logic [31:0] dcache_rdata = '0;
  logic        dcache_resp = 1'b0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.LDQ_TAG_W(3), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .backend_flush(backend_flush),
    .stq_valid(stq_valid), .stq_ready(stq_ready), .stq_addr(stq_addr),
    .stq_wmask(stq_wmask), .stq_wdata(stq_wdata),
    .ldq_valid(ldq_valid), .ldq_ready(ldq_ready), .ldq_addr(ldq_addr),
    .ldq_rmask(ldq_rmask), .ldq_tag(ldq_tag),
    .ldq_resp_valid(ldq_resp_valid), .ldq_resp_tag(ldq_resp_tag),
    .ldq_resp_rdata(ldq_resp_rdata),
    .dcache_addr(dcache_addr), .dcache_rmask(dcache_rmask),
    .dcache_wmask(dcache_wmask), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] rdata;
  } resp_t;
  resp_t exp_q[$];

  typedef struct {
    string       nm;
    logic        st_v;
    logic [31:0] st_addr;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic        ld_v;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic [2:0]  ld_tag;
    int          lat;
    logic [31:0] rdata;
    logic        exp_st;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic st_v, input logic [31:0] st_addr,
                              input logic [3:0] st_wmask, input logic [31:0] st_wdata,
                              input logic ld_v, input logic [31:0] ld_addr,
                              input logic [3:0] ld_rmask, input logic [2:0] ld_tag,
                              input int lat, input logic [31:0] rdata, input logic exp_st);
    vec_t v;
    v.nm = nm; v.st_v = st_v; v.st_addr = st_addr; v.st_wmask = st_wmask;
    v.st_wdata = st_wdata; v.ld_v = ld_v; v.ld_addr = ld_addr; v.ld_rmask = ld_rmask;
    v.ld_tag = ld_tag; v.lat = lat; v.rdata = rdata; v.exp_st = exp_st;
    return v;
  endfunction

  // Response scoreboard and one-hot ready check, sampled after each active edge.
  always begin : mon
    resp_t r;
    @(posedge clk);
    #2;
    check("one_ready", {31'd0, stq_ready & ldq_ready}, 32'd0);
    if (ldq_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, ldq_resp_valid}, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("resp_tag", {29'd0, ldq_resp_tag}, {29'd0, r.tag});
        check("resp_rdata", ldq_resp_rdata, r.rdata);
      end
    end
  end

  // One access from an IDLE cycle: accept, hold the cache request for lat
  // cycles, respond, then verify the return to IDLE and the response pulse.
  task automatic run_vec(input vec_t v);
    logic [31:0] ea;
    logic [7:0]  emask;
    stq_valid = v.st_v; stq_addr = v.st_addr; stq_wmask = v.st_wmask; stq_wdata = v.st_wdata;
    ldq_valid = v.ld_v; ldq_addr = v.ld_addr; ldq_rmask = v.ld_rmask; ldq_tag = v.ld_tag;
    #1;
    check({v.nm, " stq_ready"}, {31'd0, stq_ready}, {31'd0, v.exp_st});
    check({v.nm, " ldq_ready"}, {31'd0, ldq_ready}, {31'd0, !v.exp_st});
    @(negedge clk);
    stq_valid = 1'b0; ldq_valid = 1'b0;
    #1;
    ea    = v.exp_st ? {v.st_addr[31:2], 2'b00} : {v.ld_addr[31:2], 2'b00};
    emask = v.exp_st ? {4'h0, v.st_wmask} : {v.ld_rmask, 4'h0};
    check({v.nm, " dcache_addr"}, dcache_addr, ea);
    if (v.exp_st) check({v.nm, " dcache_wdata"}, dcache_wdata, v.st_wdata);
    for (int k = 1; k < v.lat; k++) begin
      check({v.nm, " masks_held"}, {24'd0, dcache_rmask, dcache_wmask}, {24'd0, emask});
      @(negedge clk);
      #1;
    end
    check({v.nm, " masks_last"}, {24'd0, dcache_rmask, dcache_wmask}, {24'd0, emask});
    dcache_resp = 1'b1; dcache_rdata = v.rdata;
    if (!v.exp_st) exp_q.push_back('{tag: v.ld_tag, rdata: v.rdata});
    @(negedge clk);
    dcache_resp = 1'b0; dcache_rdata = 32'h0;
    #1;
    check({v.nm, " resp_valid"}, {31'd0, ldq_resp_valid}, {31'd0, !v.exp_st});
    check({v.nm, " idle_masks"}, {24'd0, dcache_rmask, dcache_wmask}, 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " stq_ready"}, {31'd0, stq_ready}, 32'd0);
    check({nm, " ldq_ready"}, {31'd0, ldq_ready}, 32'd0);
    check({nm, " resp_valid"}, {31'd0, ldq_resp_valid}, 32'd0);
    check({nm, " resp_tag"}, {29'd0, ldq_resp_tag}, 32'd0);
    check({nm, " resp_rdata"}, ldq_resp_rdata, 32'd0);
    check({nm, " dcache_addr"}, dcache_addr, 32'd0);
    check({nm, " dcache_masks"}, {24'd0, dcache_rmask, dcache_wmask}, 32'd0);
    check({nm, " dcache_wdata"}, dcache_wdata, 32'd0);
  endtask

  initial begin
    vecs[0] = mk("cont0", 1, 32'h1000_0100, 4'hF, 32'hAAAA_0000, 1, 32'h2000_0100, 4'hF, 3'd1, 2, 32'h1111_1111, 1);
    vecs[1] = mk("cont1", 1, 32'h1000_0104, 4'hF, 32'hAAAA_0001, 1, 32'h2000_0100, 4'hF, 3'd1, 2, 32'h1111_1111, 0);
    vecs[2] = mk("cont2", 1, 32'h1000_0104, 4'h3, 32'hAAAA_0001, 1, 32'h2000_0104, 4'hF, 3'd2, 2, 32'h2222_2222, 1);
    vecs[3] = mk("cont3", 1, 32'h1000_0108, 4'hF, 32'hAAAA_0002, 1, 32'h2000_0104, 4'hF, 3'd2, 2, 32'h2222_2222, 0);
    vecs[4] = mk("store_only", 1, 32'h1000_0006, 4'hC, 32'hDEAD_BEEF, 0, 32'h0, 4'h0, 3'd0, 3, 32'h0, 1);
    vecs[5] = mk("load_only", 0, 32'h0, 4'h0, 32'h0, 1, 32'h2000_0010, 4'hF, 3'd5, 3, 32'h1234_5678, 0);
    vecs[6] = mk("load_minlat", 0, 32'h0, 4'h0, 32'h0, 1, 32'h3000_0003, 4'h8, 3'd7, 1, 32'hCAFE_F00D, 0);
    vecs[7] = mk("cont_after_ld", 1, 32'h1000_0200, 4'h1, 32'h0000_00AA, 1, 32'h2000_0200, 4'hF, 3'd0, 2, 32'h0, 1);
    vecs[8] = mk("store_minlat", 1, 32'h1000_0301, 4'h6, 32'h0BAD_F00D, 0, 32'h0, 4'h0, 3'd0, 1, 32'h0, 1);
    vecs[9] = mk("cont_after_st", 1, 32'h1000_0400, 4'hF, 32'h0, 1, 32'h2000_0400, 4'hF, 3'd6, 2, 32'h6666_6666, 0);

    // Reset state, with both valids asserted to show ready is masked.
    stq_valid = 1'b1; ldq_valid = 1'b1;
    #2;
    check_all_zero("reset");
    stq_valid = 1'b0; ldq_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Flush the cycle after accepting load tag 2: request held, no response.
    ldq_valid = 1'b1; ldq_addr = 32'h2000_0020; ldq_rmask = 4'h3; ldq_tag = 3'd2;
    #1;
    check("flush_ld ldq_ready", {31'd0, ldq_ready}, 32'd1);
    @(negedge clk);
    ldq_valid = 1'b0; backend_flush = 1'b1;
    #1;
    check("flush_ld rmask_flush", {28'd0, dcache_rmask}, 32'h3);
    @(negedge clk);
    backend_flush = 1'b0;
    #1;
    check("flush_ld rmask_held", {28'd0, dcache_rmask}, 32'h3);
    dcache_resp = 1'b1; dcache_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dcache_resp = 1'b0; dcache_rdata = 32'h0;
    #1;
    check("flush_ld no_resp", {31'd0, ldq_resp_valid}, 32'd0);
    check("flush_ld idle_rmask", {28'd0, dcache_rmask}, 32'd0);
    @(negedge clk);
    #1;
    check("flush_ld no_resp2", {31'd0, ldq_resp_valid}, 32'd0);
    check("flush_ld tag_hold", {29'd0, ldq_resp_tag}, 32'd6);
    check("flush_ld data_hold", ldq_resp_rdata, 32'h6666_6666);
    run_vec(mk("after_flush_ld", 0, 32'h0, 4'h0, 32'h0, 1, 32'h2000_0024, 4'hF, 3'd3, 2, 32'h3333_3333, 0));

    // Flush during a store: store completes, stq_ready low in the flush cycle.
    stq_valid = 1'b1; stq_addr = 32'h1000_0040; stq_wmask = 4'h1; stq_wdata = 32'h0000_00AB;
    #1;
    check("flush_st stq_ready", {31'd0, stq_ready}, 32'd1);
    @(negedge clk);
    backend_flush = 1'b1;
    #1;
    check("flush_st ready_low", {31'd0, stq_ready}, 32'd0);
    check("flush_st wmask_flush", {28'd0, dcache_wmask}, 32'h1);
    @(negedge clk);
    backend_flush = 1'b0; stq_valid = 1'b0;
    #1;
    check("flush_st wmask_held", {28'd0, dcache_wmask}, 32'h1);
    dcache_resp = 1'b1;
    @(negedge clk);
    dcache_resp = 1'b0;
    #1;
    check("flush_st idle_wmask", {28'd0, dcache_wmask}, 32'd0);
    check("flush_st no_resp", {31'd0, ldq_resp_valid}, 32'd0);

    // Flush in IDLE: nothing accepted and last_grant (STORE) is untouched.
    backend_flush = 1'b1; stq_valid = 1'b1; ldq_valid = 1'b1;
    #1;
    check("flush_idle stq_ready", {31'd0, stq_ready}, 32'd0);
    check("flush_idle ldq_ready", {31'd0, ldq_ready}, 32'd0);
    @(negedge clk);
    backend_flush = 1'b0;
    run_vec(mk("after_flush_idle", 1, 32'h1000_0500, 4'hF, 32'h5, 1, 32'h2000_0500, 4'hF, 3'd4, 2, 32'h4444_4444, 0));

    // Async reset in the middle of LD_WAIT.
    ldq_valid = 1'b1; ldq_addr = 32'h4000_0008; ldq_rmask = 4'hF; ldq_tag = 3'd4;
    #1;
    check("rst_mid ldq_ready", {31'd0, ldq_ready}, 32'd1);
    @(negedge clk);
    ldq_valid = 1'b0;
    #1;
    check("rst_mid rmask", {28'd0, dcache_rmask}, 32'hF);
    @(negedge clk);
    #2;
    rst = 1'b1; stq_valid = 1'b1; ldq_valid = 1'b1;
    #1;
    check_all_zero("async_rst");
    stq_valid = 1'b0; ldq_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst no_resp", {31'd0, ldq_resp_valid}, 32'd0);
    run_vec(mk("post_rst_cont", 1, 32'h1000_0600, 4'hF, 32'h77, 1, 32'h2000_0600, 4'hF, 3'd1, 2, 32'h0, 1));

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
